// File: rtl/regfile_param.sv
// Parameterised two-write/two-read register file with a per-register pending
// scoreboard and a sequential dump engine that streams every register out.
module regfile_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int R0_ZERO = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              alloc_en,
  input  logic [ADDR_W-1:0] alloc_a,
  output logic              busy0,
  output logic              busy1,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic              dump_last,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {ST_IDLE, ST_DUMP} state_e;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              dump_valid_q, dump_valid_d;
  logic              dump_last_q, dump_last_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;

  logic we0_eff, we1_eff, alloc_eff;
  logic ra0_zero, ra1_zero;

  assign we0_eff   = we0 && !((R0_ZERO != 0) && (wa0 == '0));
  assign we1_eff   = we1 && !((R0_ZERO != 0) && (wa1 == '0));
  assign alloc_eff = alloc_en && !((R0_ZERO != 0) && (alloc_a == '0));
  assign ra0_zero  = (R0_ZERO != 0) && (ra0 == '0);
  assign ra1_zero  = (R0_ZERO != 0) && (ra1 == '0);

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (we0_eff) regs_d[wa0] = wd0;
    if (we1_eff) regs_d[wa1] = wd1;
  end

  // Writes retire a pending entry; an alloc on the same edge re-arms it.
  always_comb begin
    pend_d = pend_q;
    if (we0_eff)   pend_d[wa0]     = 1'b0;
    if (we1_eff)   pend_d[wa1]     = 1'b0;
    if (alloc_eff) pend_d[alloc_a] = 1'b1;
  end

  always_comb begin
    rd0 = regs_q[ra0];
    rd1 = regs_q[ra1];
    if (BYPASS != 0) begin
      if (we1_eff && (wa1 == ra0))      rd0 = wd1;
      else if (we0_eff && (wa0 == ra0)) rd0 = wd0;
      if (we1_eff && (wa1 == ra1))      rd1 = wd1;
      else if (we0_eff && (wa0 == ra1)) rd1 = wd0;
    end
    if (ra0_zero) rd0 = '0;
    if (ra1_zero) rd1 = '0;
  end

  assign busy0 = pend_q[ra0] && !ra0_zero;
  assign busy1 = pend_q[ra1] && !ra1_zero;

  // Handshake: dump_req is a level sampled only in IDLE (ignored while busy);
  // dump_valid has no ready -- one beat per cycle, dump_last marks the final address.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    dump_valid_d = dump_valid_q;
    dump_last_d  = dump_last_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    case (state_q)
      ST_IDLE: begin
        dump_valid_d = 1'b0;
        dump_last_d  = 1'b0;
        if (dump_req) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
        end
      end
      ST_DUMP: begin
        dump_data_d  = regs_q[ptr_q];
        dump_addr_d  = ptr_q;
        dump_valid_d = 1'b1;
        dump_last_d  = &ptr_q;
        ptr_d        = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q       <= '0;
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_last_q  <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
    end else begin
      regs_q       <= regs_d;
      pend_q       <= pend_d;
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      dump_valid_q <= dump_valid_d;
      dump_last_q  <= dump_last_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
    end
  end

  assign dump_busy  = (state_q == ST_DUMP);
  assign dump_valid = dump_valid_q;
  assign dump_last  = dump_last_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (bypass/no-R0 and no-bypass/R0-zero)
// share stimulus and are checked every cycle against an array-based model.
module tb_regfile_param;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [AW-1:0] ra0, ra1, wa0, wa1, alloc_a;
  logic [DW-1:0] wd0, wd1;
  logic          we0, we1, alloc_en, dump_req;

  logic [DW-1:0] rd0_o [2];
  logic [DW-1:0] rd1_o [2];
  logic [DW-1:0] dd_o  [2];
  logic [AW-1:0] da_o  [2];
  logic          busy0_o [2];
  logic          busy1_o [2];
  logic          db_o [2];
  logic          dv_o [2];
  logic          dl_o [2];

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(0), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(rd0_o[0]), .rd1(rd1_o[0]),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_a(alloc_a), .busy0(busy0_o[0]), .busy1(busy1_o[0]),
    .dump_req(dump_req), .dump_busy(db_o[0]), .dump_valid(dv_o[0]), .dump_last(dl_o[0]),
    .dump_addr(da_o[0]), .dump_data(dd_o[0]));

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .R0_ZERO(1), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ra0(ra0), .ra1(ra1), .rd0(rd0_o[1]), .rd1(rd1_o[1]),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_a(alloc_a), .busy0(busy0_o[1]), .busy1(busy1_o[1]),
    .dump_req(dump_req), .dump_busy(db_o[1]), .dump_valid(dv_o[1]), .dump_last(dl_o[1]),
    .dump_addr(da_o[1]), .dump_data(dd_o[1]));

  bit cfg_r0  [2] = '{1'b0, 1'b1};
  bit cfg_byp [2] = '{1'b1, 1'b0};

  // Reference model: register contents, pending flags, and the dump stream
  // as an index that is -1 when no dump is running.
  logic [DW-1:0] m_mem  [2][DEPTH];
  bit            m_pend [2][DEPTH];
  int            m_idx  [2] = '{-1, -1};
  bit            m_dv [2];
  bit            m_dl [2];
  logic [AW-1:0] m_da [2];
  logic [DW-1:0] m_dd [2];

  int  vectors = 0;
  int  errors  = 0;
  bit  chk_en  = 1'b0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int i, input logic [AW-1:0] ra);
    if (cfg_r0[i] && ra == 0) return '0;
    if (cfg_byp[i]) begin
      if (we1 && wa1 == ra) return wd1;
      if (we0 && wa0 == ra) return wd0;
    end
    return m_mem[i][ra];
  endfunction

  function automatic logic exp_busy(input int i, input logic [AW-1:0] ra);
    if (cfg_r0[i] && ra == 0) return 1'b0;
    return m_pend[i][ra];
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int j = 0; j < DEPTH; j++) begin
          m_mem[i][j]  = '0;
          m_pend[i][j] = 1'b0;
        end
        m_idx[i] = -1;
        m_dv[i] = 1'b0; m_dl[i] = 1'b0; m_da[i] = '0; m_dd[i] = '0;
      end else begin
        if (m_idx[i] < 0) begin
          m_dv[i] = 1'b0;
          m_dl[i] = 1'b0;
          if (dump_req) m_idx[i] = 0;
        end else begin
          m_dd[i]  = m_mem[i][m_idx[i]];
          m_da[i]  = AW'(m_idx[i]);
          m_dv[i]  = 1'b1;
          m_dl[i]  = (m_idx[i] == DEPTH - 1);
          m_idx[i] = (m_idx[i] == DEPTH - 1) ? -1 : m_idx[i] + 1;
        end
        if (we0 && !(cfg_r0[i] && wa0 == 0)) begin m_mem[i][wa0] = wd0; m_pend[i][wa0] = 1'b0; end
        if (we1 && !(cfg_r0[i] && wa1 == 0)) begin m_mem[i][wa1] = wd1; m_pend[i][wa1] = 1'b0; end
        if (alloc_en && !(cfg_r0[i] && alloc_a == 0)) m_pend[i][alloc_a] = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Single compare process: every output of both instances on every negedge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("rd0", i, rd0_o[i], exp_rd(i, ra0));
        chk("rd1", i, rd1_o[i], exp_rd(i, ra1));
        chk("busy0", i, busy0_o[i], exp_busy(i, ra0));
        chk("busy1", i, busy1_o[i], exp_busy(i, ra1));
        chk("dump_busy", i, db_o[i], m_idx[i] >= 0);
        chk("dump_valid", i, dv_o[i], m_dv[i]);
        chk("dump_last", i, dl_o[i], m_dl[i]);
        chk("dump_addr", i, da_o[i], m_da[i]);
        chk("dump_data", i, dd_o[i], m_dd[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0; dump_req = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] base, input logic [DW-1:0] mul);
    for (int r = 0; r < DEPTH; r += 2) begin
      we0 = 1'b1; wa0 = AW'(r);     wd0 = base + mul * DW'(r);
      we1 = 1'b1; wa1 = AW'(r + 1); wd1 = base + mul * DW'(r + 1);
      step();
    end
    idle();
  endtask

  int  beats;
  bit  seen;

  initial begin
    rst_n = 1'b0; idle();
    ra0 = '0; ra1 = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; alloc_a = '0;
    step(); step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rd0", 0, rd0_o[0], 16'h0000);
    chk("rst_busy0", 0, busy0_o[0], 1'b0);
    chk("rst_dv", 1, dv_o[1], 1'b0);
    step();
    rst_n = 1'b1;

    // Same-address double write: port 1 wins.
    we0 = 1'b1; wa0 = 3'd5; wd0 = 16'h1111;
    we1 = 1'b1; wa1 = 3'd5; wd1 = 16'h2222;
    step(); idle(); ra0 = 3'd5;
    @(negedge clk);
    chk("same_addr", 0, rd0_o[0], 16'h2222);
    chk("same_addr", 1, rd0_o[1], 16'h2222);
    step();

    // Same-cycle forwarding only on the bypass instance.
    ra0 = 3'd3; we0 = 1'b1; wa0 = 3'd3; wd0 = 16'hBEEF;
    @(negedge clk);
    chk("bypass_now", 0, rd0_o[0], 16'hBEEF);
    chk("nobypass_now", 1, rd0_o[1], 16'h0000);
    step(); idle();
    @(negedge clk);
    chk("nobypass_next", 1, rd0_o[1], 16'hBEEF);
    step();

    // Register 0: hardwired on u_b, ordinary on u_a.
    we0 = 1'b1; wa0 = 3'd0; wd0 = 16'hFFFF; alloc_en = 1'b1; alloc_a = 3'd0;
    step(); idle(); ra0 = 3'd0;
    @(negedge clk);
    chk("r0_read", 1, rd0_o[1], 16'h0000);
    chk("r0_busy", 1, busy0_o[1], 1'b0);
    chk("r0_read", 0, rd0_o[0], 16'hFFFF);
    chk("r0_busy", 0, busy0_o[0], 1'b1);
    step();

    // Scoreboard set, clear, and alloc-beats-write.
    alloc_en = 1'b1; alloc_a = 3'd4;
    step(); idle(); ra0 = 3'd4;
    @(negedge clk);
    chk("sb_alloc", 0, busy0_o[0], 1'b1);
    chk("sb_alloc", 1, busy0_o[1], 1'b1);
    step();
    we0 = 1'b1; wa0 = 3'd4; wd0 = 16'h1234;
    step(); idle();
    @(negedge clk);
    chk("sb_write", 0, busy0_o[0], 1'b0);
    chk("sb_write", 1, busy0_o[1], 1'b0);
    step();
    alloc_en = 1'b1; alloc_a = 3'd4; we1 = 1'b1; wa1 = 3'd4; wd1 = 16'h5678;
    step(); idle();
    @(negedge clk);
    chk("sb_both", 0, busy0_o[0], 1'b1);
    chk("sb_both", 1, busy0_o[1], 1'b1);
    step();

    // Dump of r = 0x10*r, with r2 overwritten on the edge that emits beat 2.
    fill(16'h0000, 16'h0010);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    beats = 0;
    for (int j = 1; j <= 11; j++) begin
      idle();
      if (j == 3) begin we0 = 1'b1; wa0 = 3'd2; wd0 = 16'hAAAA; end
      @(negedge clk);
      if (j == 1) chk("dump_started", 0, db_o[0], 1'b1);
      if (dv_o[0]) begin
        for (int i = 0; i < 2; i++) begin
          chk("beat_addr", i, da_o[i], beats);
          chk("beat_data", i, dd_o[i], 16'h0010 * beats);
          chk("beat_last", i, dl_o[i], beats == DEPTH - 1);
        end
        beats++;
      end
      step();
    end
    idle();
    chk("dump_beats", 0, beats, DEPTH);

    // Reset during beat 4 aborts the dump; reset beats same-cycle activity.
    fill(16'h0100, 16'h0001);
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 20 && !seen; j++) begin
      @(negedge clk);
      if (dv_o[0] && da_o[0] == 3'd4) seen = 1'b1;
      else step();
    end
    chk("beat4_seen", 0, seen, 1'b1);
    rst_n = 1'b0;
    we0 = 1'b1; wa0 = 3'd1; wd0 = 16'h5555; alloc_en = 1'b1; alloc_a = 3'd1; dump_req = 1'b1;
    step(); idle(); rst_n = 1'b1; ra0 = 3'd1; ra1 = 3'd4;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("abort_dv", i, dv_o[i], 1'b0);
      chk("abort_db", i, db_o[i], 1'b0);
      chk("abort_rd0", i, rd0_o[i], 16'h0000);
      chk("abort_rd1", i, rd1_o[i], 16'h0000);
      chk("abort_busy0", i, busy0_o[i], 1'b0);
    end
    step();

    // Randomised traffic with occasional resets and dump requests.
    for (int n = 0; n < 3000; n++) begin
      rst_n    = ($urandom_range(0, 249) != 0);
      ra0      = AW'($urandom_range(0, DEPTH - 1));
      ra1      = AW'($urandom_range(0, DEPTH - 1));
      we0      = 1'($urandom_range(0, 1));
      wa0      = AW'($urandom_range(0, DEPTH - 1));
      wd0      = DW'($urandom);
      we1      = 1'($urandom_range(0, 1));
      wa1      = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, DEPTH - 1));
      wd1      = DW'($urandom);
      alloc_en = ($urandom_range(0, 2) == 0);
      alloc_a  = AW'($urandom_range(0, DEPTH - 1));
      dump_req = ($urandom_range(0, 11) == 0);
      step();
    end
    rst_n = 1'b1; idle();
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
